// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU-sharing arbiter slice.
// Holds the ALU opcode encodings, the opcode width and the requester tag
// width. Every file in the slice imports this package, so no file needs its
// own opcode definitions.
package alu_share_arbiter_pkg;

  localparam int OP_W  = 4;
  localparam int TAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT = 4'd5;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester port of the ALU-sharing arbiter.
// Request channel : req_valid/req_ready plus op, operands a/b and a tag.
// Response channel: rsp_valid/rsp_ready plus result, zero/overflow flags and
//                   the returned tag.
// Modports: master = requester side, slave = arbiter side.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int N = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_op;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_tag
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way combinational arbiter.
// Ports: eligible[1:0] (candidate ports), last_grant (port that won most
// recently), fixed_prio (1 = port 0 always wins), grant[1:0] (one-hot or
// zero).
module alu_share_arbiter_rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  // Pick a single winner; under contention the port that did not win last
  // time goes first unless fixed priority is selected.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (fixed_prio || last_grant) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters
// (port0 = pipeline EX stage, port1 = auxiliary unit).
// Ports: clock, reset (synchronous, active high); port0/port1 requester
// interfaces; alu_op/alu_a/alu_b drive the ALU and alu_out/alu_zero/
// alu_overflow come back from it in the same cycle; stall0_cnt/stall1_cnt
// count saturating cycles where a request waited.
// The result of a grant lands in the port's one-entry response register on
// the following edge, so a response is valid one cycle after acceptance.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N          = 32,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  alu_share_arbiter_if.slave port0,
  alu_share_arbiter_if.slave port1,
  output logic [OP_W-1:0]  alu_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [N-1:0]     alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic [CNT_W-1:0] stall0_cnt,
  output logic [CNT_W-1:0] stall1_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [TAG_W-1:0] req_tag [2];

  logic             last_grant;
  logic [1:0]       rsp_valid;
  logic [N-1:0]     rsp_result [2];
  logic [1:0]       rsp_zero;
  logic [1:0]       rsp_overflow;
  logic [TAG_W-1:0] rsp_tag [2];
  logic [CNT_W-1:0] stall_cnt [2];

  assign req_valid = {port1.req_valid, port0.req_valid};
  assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};
  assign req_tag[0] = port0.req_tag;
  assign req_tag[1] = port1.req_tag;

  // A full slot being drained this cycle can be refilled in the same cycle.
  assign eligible = req_valid & (~rsp_valid | rsp_ready);

  alu_share_arbiter_rr_arb2 u_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .fixed_prio (1'(FIXED_PRIO != 0)),
    .grant      (grant)
  );

  assign port0.req_ready    = grant[0];
  assign port1.req_ready    = grant[1];
  assign port0.rsp_valid    = rsp_valid[0];
  assign port1.rsp_valid    = rsp_valid[1];
  assign port0.rsp_result   = rsp_result[0];
  assign port1.rsp_result   = rsp_result[1];
  assign port0.rsp_zero     = rsp_zero[0];
  assign port1.rsp_zero     = rsp_zero[1];
  assign port0.rsp_overflow = rsp_overflow[0];
  assign port1.rsp_overflow = rsp_overflow[1];
  assign port0.rsp_tag      = rsp_tag[0];
  assign port1.rsp_tag      = rsp_tag[1];
  assign stall0_cnt         = stall_cnt[0];
  assign stall1_cnt         = stall_cnt[1];

  // Route the granted port straight to the ALU; idle drives all zeros.
  always_comb begin
    alu_op = {OP_W{1'b0}};
    alu_a  = {N{1'b0}};
    alu_b  = {N{1'b0}};
    case (grant)
      2'b01: begin
        alu_op = port0.req_op;
        alu_a  = port0.req_a;
        alu_b  = port0.req_b;
      end
      2'b10: begin
        alu_op = port1.req_op;
        alu_a  = port1.req_a;
        alu_b  = port1.req_b;
      end
      default: begin
        alu_op = {OP_W{1'b0}};
        alu_a  = {N{1'b0}};
        alu_b  = {N{1'b0}};
      end
    endcase
  end

  // Response registers, round-robin pointer and saturating stall counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant   <= 1'b1;
      rsp_valid    <= 2'b00;
      rsp_zero     <= 2'b00;
      rsp_overflow <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        rsp_result[i] <= {N{1'b0}};
        rsp_tag[i]    <= {TAG_W{1'b0}};
        stall_cnt[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      if (grant != 2'b00) begin
        last_grant <= grant[1];
      end
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid[i]    <= 1'b1;
          rsp_result[i]   <= alu_out;
          rsp_zero[i]     <= alu_zero;
          rsp_overflow[i] <= alu_overflow;
          rsp_tag[i]      <= req_tag[i];
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
        if (req_valid[i] && !grant[i] && (stall_cnt[i] != CNT_MAX)) begin
          stall_cnt[i] <= stall_cnt[i] + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench: a round-robin instance (default parameters)
// and a fixed-priority instance with a 4-bit stall counter for saturation.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_share_arbiter_if #(.N(N)) p0r ();
  alu_share_arbiter_if #(.N(N)) p1r ();
  alu_share_arbiter_if #(.N(N)) p0f ();
  alu_share_arbiter_if #(.N(N)) p1f ();

  logic [OP_W-1:0] r_op, f_op;
  logic [N-1:0]    r_a, r_b, r_out, f_a, f_b, f_out;
  logic            r_z, r_ov, f_z, f_ov;
  logic [15:0]     r_s0, r_s1;
  logic [3:0]      f_s0, f_s1;

  int n_cmp = 0;
  int n_err = 0;

  // Stand-in ALU: returns {overflow, zero, result}.
  function automatic logic [N+1:0] alu_f(input logic [OP_W-1:0] op,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N-1:0] r;
    logic ov;
    r = '0;
    ov = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; ov = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      OP_SUB: begin r = a - b; ov = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {ov, (r == '0), r};
  endfunction

  assign {r_ov, r_z, r_out} = alu_f(r_op, r_a, r_b);
  assign {f_ov, f_z, f_out} = alu_f(f_op, f_a, f_b);

  alu_share_arbiter #(.N(N), .FIXED_PRIO(0), .CNT_W(16)) dut_rr (
    .clock(clock), .reset(reset), .port0(p0r.slave), .port1(p1r.slave),
    .alu_op(r_op), .alu_a(r_a), .alu_b(r_b), .alu_out(r_out),
    .alu_zero(r_z), .alu_overflow(r_ov), .stall0_cnt(r_s0), .stall1_cnt(r_s1)
  );

  alu_share_arbiter #(.N(N), .FIXED_PRIO(1), .CNT_W(4)) dut_fp (
    .clock(clock), .reset(reset), .port0(p0f.slave), .port1(p1f.slave),
    .alu_op(f_op), .alu_a(f_a), .alu_b(f_b), .alu_out(f_out),
    .alu_zero(f_z), .alu_overflow(f_ov), .stall0_cnt(f_s0), .stall1_cnt(f_s1)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic [3:0] op,
                         input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] tag);
    case (port)
      0: begin p0r.req_valid = v; p0r.req_op = op; p0r.req_a = a; p0r.req_b = b; p0r.req_tag = tag; end
      1: begin p1r.req_valid = v; p1r.req_op = op; p1r.req_a = a; p1r.req_b = b; p1r.req_tag = tag; end
      2: begin p0f.req_valid = v; p0f.req_op = op; p0f.req_a = a; p0f.req_b = b; p0f.req_tag = tag; end
      default: begin p1f.req_valid = v; p1f.req_op = op; p1f.req_a = a; p1f.req_b = b; p1f.req_tag = tag; end
    endcase
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) set_req(p, 1'b0, OP_ADD, '0, '0, 4'd0);
    p0r.rsp_ready = 1'b1; p1r.rsp_ready = 1'b1;
    p0f.rsp_ready = 1'b1; p1f.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rsp0_valid", 32'(p0r.rsp_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(p1r.rsp_valid), 32'd0);
    chk("rst_rsp0_result", p0r.rsp_result, 32'd0);
    chk("rst_rsp0_tag", 32'(p0r.rsp_tag), 32'd0);
    chk("rst_stall0", 32'(r_s0), 32'd0);
    chk("rst_stall1", 32'(r_s1), 32'd0);
    chk("rst_alu_op_idle", 32'(r_op), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single request on port 0: ADD 5+7 tag 3
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
    #1;
    chk("single_req0_ready", 32'(p0r.req_ready), 32'd1);
    chk("single_req1_ready", 32'(p1r.req_ready), 32'd0);
    chk("single_alu_a", r_a, 32'd5);
    chk("single_alu_b", r_b, 32'd7);
    after_edge();
    chk("single_rsp0_valid", 32'(p0r.rsp_valid), 32'd1);
    chk("single_rsp0_result", p0r.rsp_result, 32'd12);
    chk("single_rsp0_zero", 32'(p0r.rsp_zero), 32'd0);
    chk("single_rsp0_tag", 32'(p0r.rsp_tag), 32'd3);
    @(negedge clock);
    set_req(0, 1'b0, OP_ADD, 32'd5, 32'd7, 4'd3);
    #1;
    chk("idle_alu_a_zero", r_a, 32'd0);
    after_edge();
    chk("drain_rsp0_valid", 32'(p0r.rsp_valid), 32'd0);
    chk("drain_rsp0_result_held", p0r.rsp_result, 32'd12);

    // Flags on port 1: SUB 9-9 then ADD 0x7FFFFFFF+1
    @(negedge clock);
    set_req(1, 1'b1, OP_SUB, 32'd9, 32'd9, 4'd5);
    #1;
    chk("flag_req1_ready", 32'(p1r.req_ready), 32'd1);
    after_edge();
    chk("sub_rsp1_valid", 32'(p1r.rsp_valid), 32'd1);
    chk("sub_rsp1_result", p1r.rsp_result, 32'd0);
    chk("sub_rsp1_zero", 32'(p1r.rsp_zero), 32'd1);
    chk("sub_rsp1_ovf", 32'(p1r.rsp_overflow), 32'd0);
    chk("sub_rsp1_tag", 32'(p1r.rsp_tag), 32'd5);
    @(negedge clock);
    set_req(1, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd6);
    after_edge();
    chk("ovf_rsp1_result", p1r.rsp_result, 32'h8000_0000);
    chk("ovf_rsp1_ovf", 32'(p1r.rsp_overflow), 32'd1);
    chk("ovf_rsp1_zero", 32'(p1r.rsp_zero), 32'd0);
    chk("ovf_rsp1_tag", 32'(p1r.rsp_tag), 32'd6);
    @(negedge clock);
    set_req(1, 1'b0, OP_ADD, '0, '0, 4'd0);
    after_edge();
    chk("ovf_rsp1_drained", 32'(p1r.rsp_valid), 32'd0);
    chk("solo_stall0", 32'(r_s0), 32'd0);
    chk("solo_stall1", 32'(r_s1), 32'd0);

    // Round-robin: both valid, starts with port 0 (port 1 won last)
    @(negedge clock);
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2, 4'd1);
    set_req(1, 1'b1, OP_SUB, 32'd10, 32'd3, 4'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_req0_ready_%0d", k), 32'(p0r.req_ready), 32'((k % 2) == 0));
      chk($sformatf("rr_req1_ready_%0d", k), 32'(p1r.req_ready), 32'((k % 2) == 1));
      after_edge();
      chk($sformatf("rr_stall0_%0d", k), 32'(r_s0), 32'((k + 1) / 2));
      chk($sformatf("rr_stall1_%0d", k), 32'(r_s1), 32'((k + 2) / 2));
      if ((k % 2) == 0) begin
        chk($sformatf("rr_rsp0_result_%0d", k), p0r.rsp_result, 32'd3);
        chk($sformatf("rr_rsp0_valid_%0d", k), 32'(p0r.rsp_valid), 32'd1);
      end else begin
        chk($sformatf("rr_rsp1_result_%0d", k), p1r.rsp_result, 32'd7);
        chk($sformatf("rr_rsp0_drained_%0d", k), 32'(p0r.rsp_valid), 32'd0);
      end
      @(negedge clock);
    end

    // Back-pressure isolation on port 0
    p0r.rsp_ready = 1'b0;
    #1;
    chk("bp_first_req0_ready", 32'(p0r.req_ready), 32'd1);
    after_edge();
    chk("bp_rsp0_valid", 32'(p0r.rsp_valid), 32'd1);
    @(negedge clock);
    set_req(0, 1'b1, OP_ADD, 32'd20, 32'd22, 4'd9);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("bp_req0_ready_%0d", k), 32'(p0r.req_ready), 32'd0);
      chk($sformatf("bp_req1_ready_%0d", k), 32'(p1r.req_ready), 32'd1);
      after_edge();
      chk($sformatf("bp_rsp0_hold_%0d", k), p0r.rsp_result, 32'd3);
      chk($sformatf("bp_rsp0_full_%0d", k), 32'(p0r.rsp_valid), 32'd1);
      @(negedge clock);
    end
    p0r.rsp_ready = 1'b1;
    #1;
    chk("refill_req0_ready", 32'(p0r.req_ready), 32'd1);
    chk("refill_req1_ready", 32'(p1r.req_ready), 32'd0);
    after_edge();
    chk("refill_rsp0_valid", 32'(p0r.rsp_valid), 32'd1);
    chk("refill_rsp0_result", p0r.rsp_result, 32'd42);
    chk("refill_rsp0_tag", 32'(p0r.rsp_tag), 32'd9);
    chk("bp_stall0", 32'(r_s0), 32'd4);
    chk("bp_stall1", 32'(r_s1), 32'd4);

    // Reset mid-stream: rsp0 full, port 1 granted in the reset cycle
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_req1_ready", 32'(p1r.req_ready), 32'd1);
    after_edge();
    chk("midrst_rsp0_valid", 32'(p0r.rsp_valid), 32'd0);
    chk("midrst_rsp1_valid", 32'(p1r.rsp_valid), 32'd0);
    chk("midrst_rsp1_result", p1r.rsp_result, 32'd0);
    chk("midrst_stall0", 32'(r_s0), 32'd0);
    chk("midrst_stall1", 32'(r_s1), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("postrst_req0_ready", 32'(p0r.req_ready), 32'd1);
    chk("postrst_req1_ready", 32'(p1r.req_ready), 32'd0);
    @(negedge clock);
    set_req(0, 1'b0, OP_ADD, '0, '0, 4'd0);
    set_req(1, 1'b0, OP_ADD, '0, '0, 4'd0);

    // Fixed priority with 4-bit counters: port 0 always, stall1 saturates at 15
    set_req(2, 1'b1, OP_OR, 32'hF0, 32'h0F, 4'd4);
    set_req(3, 1'b1, OP_AND, 32'hFF, 32'h3C, 4'd8);
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("fp_req0_ready_%0d", k), 32'(p0f.req_ready), 32'd1);
      chk($sformatf("fp_req1_ready_%0d", k), 32'(p1f.req_ready), 32'd0);
      after_edge();
      chk($sformatf("fp_stall1_%0d", k), 32'(f_s1), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
      chk($sformatf("fp_stall0_%0d", k), 32'(f_s0), 32'd0);
      @(negedge clock);
    end
    chk("fp_rsp0_result", p0f.rsp_result, 32'hFF);
    chk("fp_rsp1_valid", 32'(p1f.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the pipeline EX stage, port 1 is an auxiliary unit (address generation or a multicycle helper).
- Each port uses a valid/ready request channel and a valid/ready response channel with a one-entry response register.
- Arbitration is round-robin or fixed-priority (port 0 wins). Results return one cycle after grant.

Parameters:
- N, 32, datapath width of operands and result.
- FIXED_PRIO, 0, 1 = port 0 always wins contention; 0 = round-robin.
- CNT_W, 16, width of the per-port saturating stall counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle (equals grant).
- req0_op / req1_op  in  4  ALU opcode, from the shared opcode constants.
- req0_a, req0_b / req1_a, req1_b  in  N  operands.
- req0_tag / req1_tag  in  4  requester tag, returned unchanged.
- rsp0_valid / rsp1_valid  out  1  response register full.
- rsp0_ready / rsp1_ready  in  1  consumer takes the response.
- rsp0_result / rsp1_result  out  N  registered ALU result.
- rsp0_zero, rsp0_overflow / rsp1_zero, rsp1_overflow  out  1  registered ALU flags.
- rsp0_tag / rsp1_tag  out  4  registered tag.
- alu_op  out  4  opcode to the ALU.
- alu_a, alu_b  out  N  operands to the ALU.
- alu_out  in  N  ALU result.
- alu_zero, alu_overflow  in  1  ALU flags.
- stall0_cnt / stall1_cnt  out  CNT_W  cycles with valid high and ready low.

Behaviour:
- Reset: all rsp*_valid = 0; rsp result, flags and tag = 0; stall counters = 0; RR pointer set so port 0 is preferred first (last_grant = 1).
- Eligibility of port i: req_i_valid AND (rsp_i_valid = 0 OR rsp_i_ready = 1). A full response slot that is being drained in the same cycle may be refilled in that cycle, so each port sustains 1 op/cycle.
- Grant (combinational, one-hot or none):
  - Only one port eligible: that port is granted.
  - Both eligible, FIXED_PRIO = 1: port 0 is granted.
  - Both eligible, FIXED_PRIO = 0: the port that is not last_grant is granted.
  - req_i_ready = grant_i.
- ALU drive:
  - With a grant, alu_op/alu_a/alu_b are muxed from the granted port.
  - With no grant, alu_op/alu_a/alu_b are driven to all zeros.
  - No registers sit between the request and the ALU.
- On the clock edge with grant_i:
  - rsp_i_result ← alu_out; rsp_i_zero ← alu_zero; rsp_i_overflow ← alu_overflow; rsp_i_tag ← req_i_tag.
  - rsp_i_valid ← 1.
  - last_grant ← i. last_grant updates only on a grant, and also updates in fixed mode (unused there).
- Response drain: rsp_i_valid=1, rsp_i_ready=1 and no new grant to i: rsp_i_valid ← 0. The data registers hold their old value.
- Latency: request accepted in cycle t → response valid in cycle t+1.
- Back-pressure: with rsp_i_valid=1 and rsp_i_ready=0, port i is ineligible. The other port receives the ALU that cycle, so there is no head-of-line blocking across ports.
- Stall counter i increments when req_i_valid=1 and req_i_ready=0. It saturates at all ones and does not wrap.
- Protocol: requesters hold valid and payload stable until ready. req_i_ready may depend combinationally on req_i_valid and rsp_i_ready; requesters must not make valid depend on ready.
- Reset asserted mid-operation: pending responses are discarded, and any grant in that cycle has no effect.
- Width: the result is passed through unmodified at N bits; no sign or zero extension is done here.

Decomposition:
- Opcode constants come from the shared constants/config includes; no local opcode definitions.
- Add a shared define for the tag width (4) alongside them.
- One natural sub-module: rr_arb2. Inputs: eligible[1:0], last_grant, fixed_prio. Output: one-hot grant[1:0]. Purely combinational.
- The arbiter top holds the response registers, the pointer and the counters.

Test Plan:
- Single request: reset, then req0 {ADD, a=5, b=7, tag=3} with rsp0_ready=1 → req0_ready=1 in cycle t; rsp0_valid=1 in t+1 with result=12, zero=0, tag=3.
- Round-robin: FIXED_PRIO=0, both ports continuously valid, both rsp_ready=1 → grants alternate 0,1,0,1 starting with port 0; both stall counters increment by 1 every 2 cycles.
- Fixed priority: FIXED_PRIO=1, both ports continuously valid → port 0 granted every cycle; stall1_cnt increments every cycle and saturates at 0xFFFF.
- Back-pressure isolation: rsp0_ready=0 with rsp0 full, both ports requesting → port 1 granted every cycle; after rsp0_ready rises, port 0 is granted the same cycle (drain and refill) and rsp0_valid stays 1.
- Zero/overflow flags: req1 {SUB, a=9, b=9} → rsp1_result=0, rsp1_zero=1; req1 {ADD, a=0x7FFFFFFF, b=1} → rsp1_overflow reflects the alu_overflow input.
- Reset mid-stream: assert reset while rsp0_valid=1 and a grant is active → next cycle all rsp*_valid=0, counters=0, and the next contention grants port 0 first.
